csr_arbiter: RTL and testbench
==============================

Name: csr_arbiter

Overview:
- Shared CSR bank with a two-port access arbiter.
- Port 0 is the core pipeline, which issues CSR instructions from the decode/execute stage.
- Port 1 is the hardware side (interrupt/trap controller). It needs atomic multi-CSR sequences, for example saving mepc and mcause on trap entry.
- The block arbitrates single-cycle read-modify-write accesses to one NUM_CSR-entry bank and returns the pre-op value one cycle after grant.

Parameters:
- NUM_CSR, 8, number of 32-bit registers in the bank.
- BASE_ADDR, 12'h300, CSR address of entry 0. Entries are contiguous.
- LOCK_MAX, 16, maximum cycles port 1 may hold the lock before a forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid[1:0]  in  2  request valid, per port.
- req_ready[1:0]  out  2  grant, per port. A transfer occurs when valid & ready.
- req0_addr, req1_addr  in  12 (csr_addr_t)  CSR address.
- req0_op, req1_op  in  3 (csr_t)  operation.
- req0_data, req1_data  in  32 (word)  rs1_data operand.
- req0_zimm, req1_zimm  in  5 (r)  immediate operand, zero-extended to 32 bits.
- lock1  in  1  port 1 requests exclusive ownership.
- rsp_valid[1:0]  out  2  response valid, per port.
- rsp_rdata  out  32  CSR value before the op. One shared bus; rsp_valid identifies the owner.
- rsp_miss  out  1  access was illegal, no write occurred.
- lock_timeout  out  1  sticky flag, set on forced lock release.

Behaviour:
- Reset values:
  - All bank entries = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_miss = 0, lock_timeout = 0.
  - Lock state = IDLE, round-robin pointer = port 0 priority, lock counter = 0.
  - A reset asserted mid-access discards any pending response.
- Op encoding (csr_t): CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, CSRRWI=3'b101, CSRRSI=3'b110, CSRRCI=3'b111.
  - Immediate variants use the zero-extended zimm as the operand.
  - New value: W gives operand; S gives old|operand; C gives old&~operand.
- req_ready is combinational from the current req_valid and state. At most one bit is set per cycle.
- IDLE arbitration:
  - If only one port is valid, grant it.
  - If both are valid, grant the port not granted last.
  - The pointer updates only on a grant.
- LOCKED state:
  - Entered at the clock edge of a port-1 grant with lock1 = 1.
  - While LOCKED, req_ready[0] = 0 and port 1 is granted whenever valid.
  - Exit to IDLE on any cycle with lock1 = 0.
  - The counter increments each LOCKED cycle. On reaching LOCK_MAX: forced exit to IDLE, lock_timeout set to 1 (held until reset), and the pointer is set to favour port 0. lock1 must be deasserted and re-asserted with a new grant before LOCKED can be re-entered.
- Access timing:
  - For a grant in cycle t, the bank is written at the end of cycle t.
  - In cycle t+1: rsp_valid[p] = 1, rsp_rdata = old value, rsp_miss = miss flag.
  - Back-to-back accesses to the same address see the updated value; no hazard stall.
  - Throughput is one access per cycle.
- Miss conditions (no write, rsp_rdata = 0, rsp_miss = 1):
  - addr outside [BASE_ADDR, BASE_ADDR+NUM_CSR).
  - op 3'b000 or 3'b100.
  - addr[11:10] == 2'b11 (read-only space) with any op that would write.
- A set or clear with operand 0 performs a read only: bank unchanged, rsp_miss = 0.
- rsp_valid is a one-cycle pulse; there is no backpressure on responses.

Test Plan:
1. Port 0, CSRRW, addr 0x300, data 0xB → rsp_valid[0] at t+1, rdata 0. A following CSRRS with data 0xC returns 0xB; the entry becomes 0xF.
2. Continuing from 1:
   - CSRRC with data 0xC returns 0xF.
   - CSRRWI with zimm 1 returns 0x3.
   - CSRRSI with zimm 2 returns 0x1.
   - CSRRCI with zimm 1 returns 0x3; the final entry is 0x2.
3. Both ports valid continuously to different addresses → grants alternate 0,1,0,1. Each rsp_valid bit fires one cycle after its own grant.
4. Port 1 with lock1 = 1 does 3 writes while port 0 is valid → req_ready[0] = 0 throughout. Deasserting lock1 lets port 0 be granted the next cycle.
5. Hold lock1 = 1 for more than LOCK_MAX cycles with port 0 valid → forced release, lock_timeout = 1, port 0 granted.
6. Miss cases, each checked for rsp_miss = 1, rdata 0 and an unchanged bank:
   - addr 0x308 with NUM_CSR = 8.
   - op 3'b000.
   - reset asserted in the grant cycle → no rsp_valid follows, bank all 0.

Source files
------------

// File: rtl/csr_arbiter.sv
// csr_arbiter: shared NUM_CSR x 32-bit CSR bank behind a two-port arbiter.
//   Port 0 is the core pipeline. Port 1 is the interrupt/trap controller and can take an
//   exclusive lock so that a sequence of accesses is atomic.
//   Each granted access is a single-cycle read-modify-write. The bank is written at the end
//   of the grant cycle, and the pre-op value is returned on the following cycle.
// Ports:
//   i_clk, i_reset                        clock, synchronous active-high reset
//   i_req_valid[1:0] / o_req_ready[1:0]   per-port request handshake (ready is the grant)
//   i_reqN_addr/op/data/zimm              CSR address, op (csr_t), rs1 operand, immediate
//   i_lock1                               port 1 requests exclusive ownership
//   o_rsp_valid[1:0]                      one-cycle response pulse, identifies the owner
//   o_rsp_rdata, o_rsp_miss               pre-op value (0 on a miss), illegal-access flag
//   o_lock_timeout                        sticky, set when the lock is forcibly released
module csr_arbiter #(
  parameter int unsigned NUM_CSR   = 8,
  parameter logic [11:0] BASE_ADDR = 12'h300,
  parameter int unsigned LOCK_MAX  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [11:0] i_req0_addr,
  input  logic [11:0] i_req1_addr,
  input  logic [2:0]  i_req0_op,
  input  logic [2:0]  i_req1_op,
  input  logic [31:0] i_req0_data,
  input  logic [31:0] i_req1_data,
  input  logic [4:0]  i_req0_zimm,
  input  logic [4:0]  i_req1_zimm,
  input  logic        i_lock1,
  output logic [1:0]  o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_miss,
  output logic        o_lock_timeout
);

  localparam int unsigned IdxW = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
  // One past the last valid address, one bit wider so it cannot wrap.
  localparam logic [12:0] EndAddr = 13'(BASE_ADDR) + 13'(NUM_CSR);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_prio1;       // 1: port 1 wins a tie (port 0 was granted last)
  logic             r_lock_block;  // lock re-entry blocked until lock1 drops
  logic             r_timeout;
  logic [1:0]       r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_miss;
  logic [31:0]      r_bank [NUM_CSR];

  logic [1:0]       w_ready;
  logic             w_grant;
  logic             w_sel1;
  logic [11:0]      w_addr;
  logic [2:0]       w_op;
  logic [31:0]      w_operand;
  logic [IdxW-1:0]  w_idx;
  logic             w_in_range;
  logic             w_writes;
  logic             w_miss;
  logic [31:0]      w_old;
  logic [31:0]      w_new;
  logic             w_do_write;

  // Grant is combinational; reset forces it low so nothing is accepted during reset.
  always_comb begin
    w_ready = 2'b00;
    if (!i_reset) begin
      if (r_state == StLocked) begin
        w_ready[1] = i_req_valid[1];
      end else begin
        unique case (i_req_valid)
          2'b01:   w_ready = 2'b01;
          2'b10:   w_ready = 2'b10;
          2'b11:   w_ready = r_prio1 ? 2'b10 : 2'b01;
          default: w_ready = 2'b00;
        endcase
      end
    end
  end

  assign o_req_ready = w_ready;
  assign w_grant     = |w_ready;
  assign w_sel1      = w_ready[1];

  // Access path for the granted port.
  always_comb begin
    w_addr     = w_sel1 ? i_req1_addr : i_req0_addr;
    w_op       = w_sel1 ? i_req1_op   : i_req0_op;
    if (w_op[2]) begin
      w_operand = w_sel1 ? {27'b0, i_req1_zimm} : {27'b0, i_req0_zimm};
    end else begin
      w_operand = w_sel1 ? i_req1_data : i_req0_data;
    end
    w_idx      = IdxW'(w_addr - BASE_ADDR);
    w_in_range = (w_addr >= BASE_ADDR) && ({1'b0, w_addr} < EndAddr);
    // Set/clear with a zero operand is a pure read.
    w_writes   = (w_op[1:0] == 2'b01) || (w_operand != 32'b0);
    w_miss     = !w_in_range || (w_op[1:0] == 2'b00) ||
                 ((w_addr[11:10] == 2'b11) && w_writes);
    w_old      = w_in_range ? r_bank[w_idx] : 32'b0;
    unique case (w_op[1:0])
      2'b01:   w_new = w_operand;
      2'b10:   w_new = w_old | w_operand;
      2'b11:   w_new = w_old & ~w_operand;
      default: w_new = w_old;
    endcase
    w_do_write = w_grant && !w_miss && w_writes;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CSR; i++) r_bank[i] <= 32'b0;
    end else if (w_do_write) begin
      r_bank[w_idx] <= w_new;
    end
  end

  // Lock FSM, round-robin pointer and registered response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_prio1      <= 1'b0;
      r_lock_block <= 1'b0;
      r_timeout    <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rsp_rdata  <= 32'b0;
      r_rsp_miss   <= 1'b0;
    end else begin
      r_rsp_valid <= w_ready;
      r_rsp_rdata <= (w_grant && !w_miss) ? w_old : 32'b0;
      r_rsp_miss  <= w_grant && w_miss;

      if (w_ready[0]) begin
        r_prio1 <= 1'b1;
      end else if (w_ready[1]) begin
        r_prio1 <= 1'b0;
      end

      if (!i_lock1) r_lock_block <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_ready[1] && i_lock1 && !r_lock_block) begin
            r_state <= StLocked;
            r_cnt   <= '0;
          end
        end
        StLocked: begin
          if (!i_lock1) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else if (r_cnt == CntW'(LOCK_MAX - 1)) begin
            // Forced release: hand priority to port 0, block re-lock until lock1 drops.
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_timeout    <= 1'b1;
            r_prio1      <= 1'b0;
            r_lock_block <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_miss     = r_rsp_miss;
  assign o_lock_timeout = r_timeout;

endmodule

// File: tb/tb_csr_arbiter.sv
module tb_csr_arbiter;

  localparam int          NUM_CSR  = 8;
  localparam logic [11:0] BASE     = 12'h300;
  localparam int          LOCK_MAX = 16;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [11:0] req0_addr, req1_addr;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_data, req1_data, rsp_rdata;
  logic [4:0]  req0_zimm, req1_zimm;
  logic        lock1, rsp_miss, lock_timeout;

  always #5 clk = ~clk;

  csr_arbiter #(
    .NUM_CSR  (NUM_CSR),
    .BASE_ADDR(BASE),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req0_addr   (req0_addr),
    .i_req1_addr   (req1_addr),
    .i_req0_op     (req0_op),
    .i_req1_op     (req1_op),
    .i_req0_data   (req0_data),
    .i_req1_data   (req1_data),
    .i_req0_zimm   (req0_zimm),
    .i_req1_zimm   (req1_zimm),
    .i_lock1       (lock1),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_miss    (rsp_miss),
    .o_lock_timeout(lock_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bank contents, lock occupancy in cycles, last granted port.
  logic [31:0] m_bank [NUM_CSR];
  bit          m_locked, m_blocked, m_timeout;
  int          m_lock_cycles;
  int          m_last;
  logic [1:0]  m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_miss;
  logic [1:0]  seen_ready;

  task automatic model_reset();
    for (int i = 0; i < NUM_CSR; i++) m_bank[i] = 32'b0;
    m_locked = 0; m_blocked = 0; m_timeout = 0; m_lock_cycles = 0;
    m_last = 1;
    m_rsp_valid = 2'b00; m_rsp_rdata = 32'b0; m_rsp_miss = 1'b0;
  endtask

  // Inputs are already driven; check grant mid-cycle, step the model, then check the response.
  task automatic tick();
    logic [1:0]  exp_ready;
    int          g, idx;
    logic [11:0] a;
    logic [2:0]  op;
    logic [31:0] opnd, old, nv;
    bit          writes, miss;
    #3;
    seen_ready = req_ready;
    exp_ready = 2'b00;
    g = -1;
    if (!reset) begin
      if (m_locked) begin
        if (req_valid[1]) g = 1;
      end else if (req_valid == 2'b11) g = (m_last == 0) ? 1 : 0;
      else if (req_valid[0]) g = 0;
      else if (req_valid[1]) g = 1;
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", {30'b0, seen_ready}, {30'b0, exp_ready});
    if (reset) begin
      model_reset();
    end else begin
      m_rsp_valid = exp_ready; m_rsp_rdata = 32'b0; m_rsp_miss = 1'b0;
      if (g >= 0) begin
        a    = (g == 1) ? req1_addr : req0_addr;
        op   = (g == 1) ? req1_op : req0_op;
        opnd = op[2] ? 32'((g == 1) ? req1_zimm : req0_zimm) : ((g == 1) ? req1_data : req0_data);
        writes = (op[1:0] == 2'b01) || (opnd != 0);
        miss = (a < BASE) || (32'(a) >= 32'(BASE) + NUM_CSR) || (op[1:0] == 2'b00) ||
               ((a[11:10] == 2'b11) && writes);
        if (!miss) begin
          idx = int'(a - BASE);
          old = m_bank[idx];
          case (op[1:0])
            2'b01:   nv = opnd;
            2'b10:   nv = old | opnd;
            default: nv = old & ~opnd;
          endcase
          if (writes) m_bank[idx] = nv;
          m_rsp_rdata = old;
        end
        m_rsp_miss = miss;
        m_last = g;
      end
      if (m_locked) begin
        m_lock_cycles++;
        if (!lock1) m_locked = 0;
        else if (m_lock_cycles == LOCK_MAX) begin
          m_locked = 0; m_timeout = 1; m_last = 1; m_blocked = 1;
        end
      end else if (g == 1 && lock1 && !m_blocked) begin
        m_locked = 1; m_lock_cycles = 0;
      end
      if (!lock1) m_blocked = 0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, m_rsp_valid});
    chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
    chk("rsp_miss", {31'b0, rsp_miss}, {31'b0, m_rsp_miss});
    chk("lock_timeout", {31'b0, lock_timeout}, {31'b0, m_timeout});
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] o0, input logic [11:0] a0,
                       input logic [31:0] d0, input logic [4:0] z0, input logic [2:0] o1,
                       input logic [11:0] a1, input logic [31:0] d1, input logic lk);
    req_valid = v; req0_op = o0; req0_addr = a0; req0_data = d0; req0_zimm = z0;
    req1_op = o1; req1_addr = a1; req1_data = d1; req1_zimm = 5'd0; lock1 = lk;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [2:0]  op0;
    logic [11:0] addr0;
    logic [31:0] data0;
    logic [4:0]  zimm0;
    logic [2:0]  op1;
    logic [11:0] addr1;
    logic [31:0] data1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_rdata;
    logic        exp_miss;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] v, logic [2:0] o0, logic [11:0] a0, logic [31:0] d0,
                              logic [4:0] z0, logic [2:0] o1, logic [11:0] a1, logic [31:0] d1,
                              logic [1:0] er, logic [31:0] ed, logic em);
    vec_t r;
    r.valid = v; r.op0 = o0; r.addr0 = a0; r.data0 = d0; r.zimm0 = z0;
    r.op1 = o1; r.addr1 = a1; r.data1 = d1;
    r.exp_ready = er; r.exp_rdata = ed; r.exp_miss = em;
    return r;
  endfunction

  initial begin
    logic lk;
    reset = 1'b1;
    drive(2'b00, RW, BASE, 0, 0, RW, BASE, 0, 0);
    model_reset();
    tick();
    tick();
    chk("reset_ready", {30'b0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    reset = 1'b0;

    // Directed vectors: RMW ops, miss cases, round-robin.
    tbl.push_back(mk(2'b01, RW,   12'h300, 32'hB, 0, RW, 0, 0, 2'b01, 32'h0, 0));
    tbl.push_back(mk(2'b01, RS,   12'h300, 32'hC, 0, RW, 0, 0, 2'b01, 32'hB, 0));
    tbl.push_back(mk(2'b01, RC,   12'h300, 32'hC, 0, RW, 0, 0, 2'b01, 32'hF, 0));
    tbl.push_back(mk(2'b01, RWI,  12'h300, 32'hFFFF_0000, 1, RW, 0, 0, 2'b01, 32'h3, 0));
    tbl.push_back(mk(2'b01, RSI,  12'h300, 32'hFFFF_0000, 2, RW, 0, 0, 2'b01, 32'h1, 0));
    tbl.push_back(mk(2'b01, RCI,  12'h300, 32'hFFFF_0000, 1, RW, 0, 0, 2'b01, 32'h3, 0));
    tbl.push_back(mk(2'b01, RS,   12'h300, 32'h0, 0, RW, 0, 0, 2'b01, 32'h2, 0));
    tbl.push_back(mk(2'b01, RW,   12'h308, 32'hFF, 0, RW, 0, 0, 2'b01, 32'h0, 1));
    tbl.push_back(mk(2'b01, 3'b000, 12'h300, 32'hFF, 0, RW, 0, 0, 2'b01, 32'h0, 1));
    tbl.push_back(mk(2'b01, 3'b100, 12'h300, 32'hFF, 0, RW, 0, 0, 2'b01, 32'h0, 1));
    tbl.push_back(mk(2'b01, RS,   12'h300, 32'h0, 0, RW, 0, 0, 2'b01, 32'h2, 0));
    tbl.push_back(mk(2'b11, RW,   12'h301, 32'h11, 0, RW, 12'h302, 32'h22, 2'b10, 32'h0, 0));
    tbl.push_back(mk(2'b11, RW,   12'h301, 32'h11, 0, RW, 12'h302, 32'h22, 2'b01, 32'h0, 0));
    tbl.push_back(mk(2'b11, RS,   12'h301, 32'h0, 0, RS, 12'h302, 32'h0, 2'b10, 32'h22, 0));
    tbl.push_back(mk(2'b11, RS,   12'h301, 32'h0, 0, RS, 12'h302, 32'h0, 2'b01, 32'h11, 0));
    tbl.push_back(mk(2'b00, RS,   12'h301, 32'h0, 0, RS, 12'h302, 32'h0, 2'b00, 32'h0, 0));
    tbl.push_back(mk(2'b10, RS,   12'h301, 32'h0, 0, RS, 12'h300, 32'h0, 2'b10, 32'h2, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].op0, tbl[i].addr0, tbl[i].data0, tbl[i].zimm0,
            tbl[i].op1, tbl[i].addr1, tbl[i].data1, 1'b0);
      tick();
      chk($sformatf("vec%0d_ready", i), {30'b0, seen_ready}, {30'b0, tbl[i].exp_ready});
      chk($sformatf("vec%0d_rsp_valid", i), {30'b0, rsp_valid}, {30'b0, tbl[i].exp_ready});
      chk($sformatf("vec%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_miss", i), {31'b0, rsp_miss}, {31'b0, tbl[i].exp_miss});
    end

    // Lock: three port-1 writes while port 0 waits, then release.
    drive(2'b10, RW, 12'h304, 32'h55, 0, RW, 12'h303, 32'h1, 1); tick();
    chk("lock_w1", {30'b0, seen_ready}, 32'd2);
    drive(2'b11, RW, 12'h304, 32'h55, 0, RW, 12'h305, 32'h2, 1); tick();
    chk("lock_w2", {30'b0, seen_ready}, 32'd2);
    drive(2'b11, RW, 12'h304, 32'h55, 0, RW, 12'h306, 32'h3, 1); tick();
    chk("lock_w3", {30'b0, seen_ready}, 32'd2);
    drive(2'b01, RW, 12'h304, 32'h55, 0, RW, 12'h306, 32'h3, 0); tick();
    chk("lock_drop_cycle", {30'b0, seen_ready}, 32'd0);
    tick();
    chk("lock_released_p0", {30'b0, seen_ready}, 32'd1);
    chk("lock_released_rsp", {30'b0, rsp_valid}, 32'd1);

    // Lock timeout: hold lock1 past LOCK_MAX with port 0 waiting.
    drive(2'b10, RW, 12'h304, 32'h66, 0, RS, 12'h307, 32'h0, 1); tick();
    chk("to_enter", {30'b0, seen_ready}, 32'd2);
    drive(2'b11, RW, 12'h304, 32'h66, 0, RS, 12'h307, 32'h0, 1);
    for (int i = 0; i < LOCK_MAX; i++) begin
      tick();
      chk($sformatf("to_locked%0d", i), {30'b0, seen_ready}, 32'd2);
      chk($sformatf("to_flag%0d", i), {31'b0, lock_timeout}, (i == LOCK_MAX - 1) ? 32'd1 : 32'd0);
    end
    tick();
    chk("to_p0_granted", {30'b0, seen_ready}, 32'd1);
    tick();
    chk("to_p1_no_relock", {30'b0, seen_ready}, 32'd2);
    tick();
    chk("to_alternates", {30'b0, seen_ready}, 32'd1);
    chk("to_sticky", {31'b0, lock_timeout}, 32'd1);

    // Reset in the grant cycle: no response, bank cleared.
    drive(2'b01, RW, 12'h300, 32'hAAAA, 0, RW, 12'h300, 0, 0);
    reset = 1'b1;
    tick();
    chk("rst_grant_ready", {30'b0, seen_ready}, 32'd0);
    chk("rst_no_rsp", {30'b0, rsp_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NUM_CSR; i++) begin
      drive(2'b01, RS, BASE + 12'(i), 32'h0, 0, RW, 12'h300, 0, 0);
      tick();
      chk($sformatf("rst_bank%0d", i), rsp_rdata, 32'd0);
    end

    // Random traffic against the model.
    lk = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      drive(2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 12'h2FE + 12'($urandom_range(0, 11)),
            ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom, 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), 12'h2FE + 12'($urandom_range(0, 11)),
            ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom, lk);
      req1_zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
